// File: rtl/mcu_pkg.sv
// Shared definitions for the MCU frame router: target ids, FSM states and
// a saturating byte-count helper.
package mcu_pkg;

    // Target ids carried in the first byte of each MCU frame
    localparam logic [7:0] TGT_SYSCTRL = 8'h00;
    localparam logic [7:0] TGT_HID     = 8'h01;
    localparam logic [7:0] TGT_OSD     = 8'h02;
    localparam logic [7:0] TGT_SDC     = 8'h03;
    localparam logic [7:0] TGT_STATUS  = 8'hFF;

    // Router frame state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_STAT = 2'd2,
        ST_DROP = 2'd3
    } rtr_state_t;

    // Increment that sticks at 255 instead of wrapping
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mcu_int_merge.sv
// Interrupt merge for the MCU frame router: registered AND of the per-target
// active-low requests, plus the pending bitmap captured at a frame start.
module mcu_int_merge
    import mcu_pkg::*;
#(
    parameter int unsigned NUM_TARGETS = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_TARGETS-1:0] tgt_int_n,
    input  logic                   latch_en,
    output logic                   int_out_n,
    output logic [7:0]             pending
);

    logic [7:0] pend_next;

    // Active-high pending bitmap, bits above the target count forced to 0
    always_comb begin
        pend_next = '0;
        pend_next[NUM_TARGETS-1:0] = ~tgt_int_n;
    end

    // Merged interrupt every clk; bitmap frozen at each frame start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            int_out_n <= 1'b1;
            pending   <= '0;
        end else begin
            int_out_n <= &tgt_int_n;
            if (latch_en) begin
                pending <= pend_next;
            end
        end
    end

endmodule

// File: rtl/mcu_frame_router.sv
// MCU frame router: demultiplexes the MCU byte stream to the control slaves
// selected by each frame's first byte, muxes the selected reply back and
// merges the slave interrupts.
module mcu_frame_router
    import mcu_pkg::*;
#(
    parameter int unsigned NUM_TARGETS = 4,
    parameter logic [7:0]  STATUS_ID   = TGT_STATUS
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     mcu_strobe,
    input  logic                     mcu_start,
    input  logic [7:0]               mcu_din,
    output logic [7:0]               mcu_dout,
    output logic [NUM_TARGETS-1:0]   tgt_strobe,
    output logic                     tgt_start,
    output logic [7:0]               tgt_din,
    input  logic [NUM_TARGETS*8-1:0] tgt_dout,
    input  logic [NUM_TARGETS-1:0]   tgt_int_n,
    output logic                     int_out_n,
    output logic [2:0]               active_tgt
);

    rtr_state_t             state;
    logic [2:0]             sel;
    logic                   first_flag;
    logic [7:0]             byte_cnt;
    logic                   start_strb;
    logic [7:0]             pending;
    logic [NUM_TARGETS-1:0] sel_onehot;
    logic [7:0]             reply_fwd;

    assign start_strb = mcu_strobe & mcu_start;
    assign active_tgt = sel;

    // Decode the selected target into a strobe mask and its reply byte
    always_comb begin
        sel_onehot = '0;
        reply_fwd  = '0;
        for (int unsigned k = 0; k < NUM_TARGETS; k++) begin
            if (sel == 3'(k)) begin
                sel_onehot[k] = 1'b1;
                reply_fwd     = tgt_dout[k*8 +: 8];
            end
        end
    end

    // Frame FSM: target selection on start bytes, forwarding of later bytes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            sel        <= '0;
            first_flag <= 1'b0;
            byte_cnt   <= '0;
            tgt_strobe <= '0;
            tgt_start  <= 1'b0;
            tgt_din    <= '0;
        end else begin
            tgt_strobe <= '0;
            tgt_start  <= 1'b0;
            if (mcu_strobe) begin
                if (mcu_start) begin
                    // A start always re-selects, aborting any frame in progress
                    byte_cnt <= '0;
                    if (32'(mcu_din) < NUM_TARGETS) begin
                        state      <= ST_FWD;
                        sel        <= mcu_din[2:0];
                        first_flag <= 1'b1;
                    end else if (mcu_din == STATUS_ID) begin
                        state <= ST_STAT;
                    end else begin
                        state <= ST_DROP;
                    end
                end else if (state != ST_IDLE) begin
                    byte_cnt <= sat_inc8(byte_cnt);
                    if (state == ST_FWD) begin
                        tgt_strobe <= sel_onehot;
                        tgt_din    <= mcu_din;
                        tgt_start  <= first_flag & (byte_cnt == 8'd0);
                        first_flag <= 1'b0;
                    end
                end
            end
        end
    end

    // Reply byte presented to the MCU shifter, registered every clk
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcu_dout <= '0;
        end else begin
            case (state)
                ST_FWD:  mcu_dout <= reply_fwd;
                ST_STAT: mcu_dout <= pending;
                default: mcu_dout <= '0;
            endcase
        end
    end

    mcu_int_merge #(
        .NUM_TARGETS (NUM_TARGETS)
    ) u_int_merge (
        .clk       (clk),
        .reset_n   (reset_n),
        .tgt_int_n (tgt_int_n),
        .latch_en  (start_strb),
        .int_out_n (int_out_n),
        .pending   (pending)
    );

endmodule
